booth_r4_pp_gen: RTL and testbench

- Radix-4 Booth encoder and partial-product generator; the stage directly upstream of the 4:2 compressor tree in the Booth multiplier datapath.
- Accepts one signed operand pair per transaction.
- Emits the partial-product rows four per beat, so that each beat feeds exactly one bank of 4:2 compressors (four rows plus carry-in).
- Holds output under downstream backpressure.

---
 rtl/booth_r4_pp_gen.sv | 164 ++++++++++++++++
 tb/tb_booth_r4_pp_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_pp_gen.sv
// rtl/booth_r4_pp_gen.sv - radix-4 Booth encoder emitting four partial-product rows per beat
module booth_r4_pp_gen #(
   parameter int WIDTH = 16,
   localparam int ROWS = WIDTH / 2,
   localparam int BEATS = WIDTH / 8,
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   pp0,
   output logic [WIDTH:0]   pp1,
   output logic [WIDTH:0]   pp2,
   output logic [WIDTH:0]   pp3,
   output logic [3:0]       neg,
   output logic [BW-1:0]    beat,
   output logic             last
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic          ONE_BEAT  = (BEATS == 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_pp [4];
   logic [3:0]       r_neg;
   logic [BW-1:0]    r_beat;
   logic             r_last;

   logic             w_load;
   logic             w_advance;
   logic             w_clear;
   logic [BW-1:0]    w_k;
   logic [WIDTH-1:0] w_src_a;
   logic [WIDTH:0]   w_bx;
   logic [WIDTH:0]   w_bsh;
   logic [2:0]       w_code;
   logic [WIDTH:0]   w_mag;
   logic [WIDTH:0]   w_row [4];
   logic [3:0]       w_neg;

   // Rows for the beat about to be registered: beat 0 from the live inputs at
   // acceptance, otherwise the next beat from the captured operands.
   always_comb begin
      w_k     = (r_state == S_IDLE) ? '0 : r_beat + 1'b1;
      w_src_a = (r_state == S_IDLE) ? in_a : r_a;
      w_bx    = (r_state == S_IDLE) ? {in_b, 1'b0} : {r_b, 1'b0};
      w_bsh   = w_bx >> {w_k, 3'b000};
      w_code  = '0;
      w_mag   = '0;
      w_neg   = '0;
      for (int j = 0; j < 4; j++) begin
         w_row[j] = '0;
      end
      for (int j = 0; j < 4; j++) begin
         w_code = w_bsh[2*j +: 3];
         w_mag  = '0;
         case (w_code)
            3'b001, 3'b010: w_mag = {w_src_a[WIDTH-1], w_src_a};
            3'b011:         w_mag = {w_src_a, 1'b0};
            3'b100: begin
               w_mag    = {w_src_a, 1'b0};
               w_neg[j] = 1'b1;
            end
            3'b101, 3'b110: begin
               w_mag    = {w_src_a[WIDTH-1], w_src_a};
               w_neg[j] = 1'b1;
            end
            default: w_mag = '0;
         endcase
         w_row[j] = w_neg[j] ? ~w_mag : w_mag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (out_ready) begin
               if (r_last) begin
                  w_clear     = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_neg  <= '0;
         r_beat <= '0;
         r_last <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            r_pp[j] <= '0;
         end
      end else if (w_load) begin
         r_a    <= in_a;
         r_b    <= in_b;
         r_neg  <= w_neg;
         r_beat <= '0;
         r_last <= ONE_BEAT;
         for (int j = 0; j < 4; j++) begin
            r_pp[j] <= w_row[j];
         end
      end else if (w_advance) begin
         r_neg  <= w_neg;
         r_beat <= w_k;
         r_last <= (w_k == LAST_BEAT);
         for (int j = 0; j < 4; j++) begin
            r_pp[j] <= w_row[j];
         end
      end else if (w_clear) begin
         r_neg  <= '0;
         r_beat <= '0;
         r_last <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            r_pp[j] <= '0;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_BUSY);
   assign pp0       = r_pp[0];
   assign pp1       = r_pp[1];
   assign pp2       = r_pp[2];
   assign pp3       = r_pp[3];
   assign neg       = r_neg;
   assign beat      = r_beat;
   assign last      = r_last;

endmodule

// File: tb/tb_booth_r4_pp_gen.sv
// tb/tb_booth_r4_pp_gen.sv - directed and random checks of the Booth row generator
module tb_booth_r4_pp_gen;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] pp0, pp1, pp2, pp3;
   logic [3:0]  neg;
   logic [0:0]  beat;
   logic        last;

   int checks = 0;
   int errors = 0;

   logic [16:0] cap_pp [2][4];
   logic [3:0]  cap_neg [2];
   logic        cap_last [2];
   int          nb;
   logic [31:0] sum;

   booth_r4_pp_gen #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3), .neg(neg), .beat(beat), .last(last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa, sb;
      sa = $signed({{16{a[15]}}, a});
      sb = $signed({{16{b[15]}}, b});
      return 32'(sa * sb);
   endfunction

   // One transaction: accept, then drain beats with out_ready asserted rdy_pct% of cycles.
   task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input int rdy_pct);
      logic [16:0] cur [4];
      logic [31:0] rx;
      int i;
      int cyc;
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      nb = 0; sum = '0; cyc = 0;
      while (out_valid === 1'b1 && cyc < 200) begin
         out_ready = ($urandom_range(99) < rdy_pct);
         if (out_ready) begin
            chk("beat_idx", 64'(beat), 64'(nb));
            chk("last_flag", 64'(last), 64'(nb == 1));
            cur = '{pp0, pp1, pp2, pp3};
            if (nb < 2) begin
               cap_pp[nb] = cur;
               cap_neg[nb] = neg;
               cap_last[nb] = last;
            end
            for (int j = 0; j < 4; j++) begin
               i = 4 * nb + j;
               rx = {{15{cur[j][16]}}, cur[j]};
               sum = sum + (rx << (2 * i)) + (32'(neg[j]) << (2 * i));
            end
            nb++;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk("txn_timeout", 64'(cyc < 200), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_pp0", 64'(pp0), 64'd0);
      chk("rst_neg", 64'(neg), 64'd0);
      chk("rst_beat_last", 64'({beat, last}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic product 3*5
      do_txn(16'd3, 16'd5, 100);
      chk("b_nbeats", 64'(nb), 64'd2);
      chk("b_beat0_rows", {cap_pp[0][0], cap_pp[0][1], cap_pp[0][2][14:0]}, {17'h00003, 17'h00003, 15'h0});
      chk("b_beat0_pp3", 64'(cap_pp[0][3]), 64'd0);
      chk("b_beat0_neg", 64'(cap_neg[0]), 64'd0);
      chk("b_beat0_last", 64'(cap_last[0]), 64'd0);
      chk("b_beat1_rows", 64'(cap_pp[1][0] | cap_pp[1][1] | cap_pp[1][2] | cap_pp[1][3]), 64'd0);
      chk("b_beat1_last", 64'(cap_last[1]), 64'd1);
      chk("b_sum", 64'(sum), 64'd15);
      chk("b_idle_ready", 64'(in_ready), 64'd1);
      chk("b_idle_valid", 64'(out_valid), 64'd0);

      // Negative multiplier 7 * -1
      do_txn(16'd7, 16'hFFFF, 100);
      chk("n_pp0", 64'(cap_pp[0][0]), 64'h1FFF8);
      chk("n_neg0", 64'(cap_neg[0]), 64'b0001);
      chk("n_rows123", 64'(cap_pp[0][1] | cap_pp[0][2] | cap_pp[0][3]), 64'd0);
      chk("n_beat1", 64'({cap_pp[1][0], cap_pp[1][1], cap_pp[1][2], cap_pp[1][3], cap_neg[1]}), 64'd0);
      chk("n_sum", 64'(sum), 64'(32'hFFFF_FFF9));

      // Most-negative multiplicand, B=2: product -65536
      do_txn(16'h8000, 16'd2, 100);
      chk("x_pp0", 64'(cap_pp[0][0]), 64'h0FFFF);
      chk("x_neg0", 64'(cap_neg[0]), 64'b0001);
      chk("x_pp1", 64'(cap_pp[0][1]), 64'h18000);
      chk("x_sum", 64'(sum), 64'(32'hFFFF_0000));

      // Pairwise sweep of extreme operands
      begin
         logic [15:0] ext [5];
         ext = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};
         for (int p = 0; p < 5; p++) begin
            for (int q = 0; q < 5; q++) begin
               do_txn(ext[p], ext[q], 100);
               chk("sweep_sum", 64'(sum), 64'(prod(ext[p], ext[q])));
               chk("sweep_nbeats", 64'(nb), 64'd2);
            end
         end
      end

      // Backpressure on beat 0 with an ignored in_valid pulse during BUSY
      in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("bp_valid", 64'(out_valid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         chk("bp_pp01", 64'({pp0, pp1}), {30'd0, 17'd3, 17'd3});
         chk("bp_beat", 64'({beat, last}), 64'd0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         if (c == 1) begin
            in_valid = 1'b1; in_a = 16'd7; in_b = 16'hFFFF;
         end
         tick();
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      chk("bp_rel_beat0", 64'({pp0, neg, beat}), {42'd0, 17'd3, 4'd0, 1'b0});
      tick();
      chk("bp_beat1", 64'({beat, last}), 64'b11);
      chk("bp_beat1_rows", 64'({pp0, pp1, neg}), 64'd0);
      tick();
      chk("bp_done", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      tick();
      chk("bp_no_extra", 64'(out_valid), 64'd0);

      // Asynchronous reset mid-BUSY
      in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_ready", 64'(in_ready), 64'd1);
      chk("ar_outs", 64'({pp0, pp1, pp2, neg, beat, last}), 64'd0);
      chk("ar_pp3", 64'(pp3), 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("ar_no_beat", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Random regression
      for (int t = 0; t < 10000; t++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         do_txn(ra, rb, 70);
         chk("rnd_sum", 64'(sum), 64'(prod(ra, rb)));
         chk("rnd_nbeats", 64'(nb), 64'd2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
